// File: rtl/onchipalarm_blink_pio.sv
// Multi-channel Avalon-MM output PIO with a shared blink timer.
// Channels whose MASK bit is set are blanked while the blink phase is high.
module onchipalarm_blink_pio #(
    parameter int unsigned      NCH       = 4,
    parameter int unsigned      W         = 7,
    parameter int unsigned      ADDR_W    = 3,
    parameter int unsigned      PER_W     = 24,
    parameter logic [W-1:0]     RESET_VAL = '0,
    parameter logic [W-1:0]     BLANK_VAL = '0,
    parameter logic [PER_W-1:0] DEF_PER   = PER_W'(12499999)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NCH*W-1:0]  out_port
);

    localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(NCH);
    localparam logic [ADDR_W-1:0] A_PER  = ADDR_W'(NCH + 1);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(NCH + 2);

    logic [W-1:0]     r_data [NCH];
    logic [NCH-1:0]   r_mask;
    logic [PER_W-1:0] r_per;
    logic [PER_W-1:0] r_cnt;
    logic             r_phase;

    logic             w_wr;
    logic             w_mask_wr;
    logic             w_per_wr;
    logic [PER_W-1:0] w_cnt_nxt;
    logic             w_phase_nxt;
    logic             w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_mask_wr = w_wr & (address == A_MASK);
    assign w_per_wr  = w_wr & (address == A_PER);
    assign w_unused  = ^writedata;

    // Channel data registers, one per decoded word address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                r_data[c] <= RESET_VAL;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_wr && (address == ADDR_W'(c))) begin
                    r_data[c] <= writedata[W-1:0];
                end
            end
        end
    end

    // Blink enable mask and half-period registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
            r_per  <= DEF_PER;
        end else begin
            if (w_mask_wr) begin
                r_mask <= writedata[NCH-1:0];
            end
            if (w_per_wr) begin
                r_per <= writedata[PER_W-1:0];
            end
        end
    end

    // Timer next state: a PERIOD write restarts, an empty mask parks the timer
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        if (w_per_wr) begin
            w_cnt_nxt   = writedata[PER_W-1:0];
            w_phase_nxt = 1'b0;
        end else if (r_mask == '0) begin
            w_cnt_nxt   = r_per;
            w_phase_nxt = 1'b0;
        end else if (r_cnt == '0) begin
            w_cnt_nxt   = r_per;
            w_phase_nxt = ~r_phase;
        end else begin
            w_cnt_nxt   = r_cnt - PER_W'(1);
        end
    end

    // Timer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= DEF_PER;
            r_phase <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Zero-wait read mux; DATA reads return the stored, unblanked value
    always_comb begin
        readdata = '0;
        for (int c = 0; c < NCH; c++) begin
            if (address == ADDR_W'(c)) begin
                readdata = 32'(r_data[c]);
            end
        end
        if (address == A_MASK) begin
            readdata = 32'(r_mask);
        end
        if (address == A_PER) begin
            readdata = 32'(r_per);
        end
        if (address == A_STAT) begin
            readdata = {31'd0, r_phase};
        end
    end

    // Output drive: blanked channels show BLANK_VAL during the high phase
    always_comb begin
        out_port = '0;
        for (int c = 0; c < NCH; c++) begin
            out_port[c*W +: W] = (r_mask[c] & r_phase) ? BLANK_VAL : r_data[c];
        end
    end

endmodule

// File: tb/tb_onchipalarm_blink_pio.sv
// Bench for onchipalarm_blink_pio: directed scenarios then random bus traffic.
// The reference model derives phase from edges elapsed since the last restart.
module tb_onchipalarm_blink_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [27:0] out_port;

    int total = 0;
    int bad = 0;

    logic [6:0] m_data [4];
    logic [3:0] m_mask;
    longint     m_per;
    longint     m_k;

    onchipalarm_blink_pio dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_phase();
        return ((m_k / (m_per + 1)) % 2) == 1;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        case (a)
            0, 1, 2, 3: return {25'd0, m_data[a]};
            4:          return {28'd0, m_mask};
            5:          return 32'(m_per);
            6:          return {31'd0, m_phase()};
            default:    return 32'd0;
        endcase
    endfunction

    function automatic logic [27:0] m_out();
        logic [27:0] o;
        bit ph;
        ph = m_phase();
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[c*7 +: 7] = (m_mask[c] && ph) ? 7'd0 : m_data[c];
        end
        return o;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < 4; c++) m_data[c] = 7'd0;
        m_mask = 4'd0;
        m_per  = 12499999;
        m_k    = 0;
    endtask

    task automatic m_edge(input bit cs, input bit wn, input int a,
                          input logic [31:0] wd);
        bit wr;
        wr = cs && !wn;
        if (wr && a == 5) m_k = 0;
        else if (m_mask == 4'd0) m_k = 0;
        else m_k++;
        if (wr) begin
            case (a)
                0, 1, 2, 3: m_data[a] = wd[6:0];
                4:          m_mask = wd[3:0];
                5:          m_per = longint'(wd[23:0]);
                default:    ;
            endcase
        end
    endtask

    task automatic cyc(input bit cs, input bit wn, input int a,
                       input logic [31:0] wd);
        chipselect = cs;
        write_n    = wn;
        address    = 3'(a);
        writedata  = wd;
        #1 chk("rd_pre", readdata, m_read(a));
        @(posedge clk);
        m_edge(cs, wn, a, wd);
        #1;
        chk("out", out_port, m_out());
        chk("rd_post", readdata, m_read(a));
        @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [31:0] wd);
        cyc(1'b1, 1'b0, a, wd);
    endtask

    task automatic count_to_toggle(output int n);
        logic p0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd6;
        #1 p0 = readdata[0];
        n = -1;
        for (int i = 1; i <= 50; i++) begin
            cyc(1'b0, 1'b1, 6, 32'd0);
            if (readdata[0] !== p0) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int a;
        int r;
        logic [31:0] wd;

        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        m_reset();

        #2;
        chk("rst_out", out_port, 28'd0);
        for (int i = 0; i < 8; i++) begin
            address = 3'(i);
            #1 chk("rst_rd", readdata, m_read(i));
        end
        chk("rst_per", readdata, 32'd0);
        address = 3'd5;
        #1 chk("rst_per_val", readdata, 32'd12499999);
        @(negedge clk);
        reset_n = 1'b1;

        wr(2, 32'h5B);
        wr(0, 32'h3F);
        chk("ch2", out_port[20:14], 7'h5B);
        chk("ch0", out_port[6:0], 7'h3F);
        chk("ch1", out_port[13:7], 7'h00);
        chk("ch3", out_port[27:21], 7'h00);

        for (int c = 0; c < 4; c++) wr(c, 32'h7F);
        wr(5, 32'd3);
        wr(4, 32'h5);
        count_to_toggle(n);
        chk("blink_on", n, 4);
        chk("blank_pat", out_port, {7'h7F, 7'h00, 7'h7F, 7'h00});
        count_to_toggle(n);
        chk("blink_off", n, 4);
        chk("vis_pat", out_port, {4{7'h7F}});
        count_to_toggle(n);
        chk("blink_on2", n, 4);

        wr(5, 32'd9);
        chk("restart_vis", out_port, {4{7'h7F}});
        count_to_toggle(n);
        chk("restart_10", n, 10);

        wr(4, 32'h1);
        wr(5, 32'd0);
        count_to_toggle(n);
        chk("per0_a", n, 1);
        count_to_toggle(n);
        chk("per0_b", n, 1);
        if (readdata[0] !== 1'b1) cyc(1'b0, 1'b1, 6, 32'd0);
        chk("blanked", out_port[6:0], 7'h00);
        wr(4, 32'h0);
        chk("mask0_vis", out_port, {4{7'h7F}});

        wr(6, 32'hFFFF_FFFF);
        chk("stat_wr", readdata, 32'd0);
        wr(7, 32'h0000_FFFF);
        chk("unmap_rd", readdata, 32'd0);
        chk("unmap_out", out_port, {4{7'h7F}});

        wr(1, 32'h11);
        wr(5, 32'd2);
        wr(4, 32'hF);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 6, 32'd0);
        #2 reset_n = 1'b0;
        m_reset();
        #1 chk("rst_mid_out", out_port, 28'd0);
        address = 3'd6;
        #1 chk("rst_mid_st", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 6, 32'd0);
        chk("rst_idle", readdata[0], 1'b0);
        wr(5, 32'd1);
        wr(4, 32'h3);

        for (int i = 0; i < 500; i++) begin
            a = $urandom_range(0, 7);
            r = $urandom_range(0, 9);
            wd = $urandom;
            if (r < 5) begin
                cyc(1'($urandom_range(0, 1)), 1'b1, a, wd);
            end else if (r == 5) begin
                cyc(1'b0, 1'b0, a, wd);
            end else begin
                if (a == 5) wd = 32'($urandom_range(0, 4));
                wr(a, wd);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
